// File: rtl/timer_irq_ctrl.sv
// Memory-mapped timer (TH reload, TL counter, TCON control/status) raising a registered IRQ to the CPU.
// Reads are combinational with zero latency; stores take effect on the clock edge. Optional macro: TIMER_ONESHOT_EN.
module timer_irq_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        memread,
    input  logic        memwrite,
    output logic [31:0] rdata,
    output logic        irqout
);

    localparam logic [15:0] PMAX = 16'(PRESCALE - 1);

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [15:0] r_pcnt;
    logic        r_ten;
    logic        r_ien;
    logic        r_ist;
    logic        r_osm;

    logic        w_sel;
    logic        w_th_wr;
    logic        w_tl_wr;
    logic        w_tcon_wr;
    logic        w_ten_new;
    logic        w_ien_new;
    logic        w_osm_new;
    logic        w_tick;
    logic        w_ovf;
    logic [31:0] w_tcon_rd;
    logic        w_unused_addr;

    assign w_unused_addr = &{1'b0, addr[1:0]};

    // Offset 0xC (addr[3:2]==3) is left unclaimed for other peripherals.
    assign w_sel     = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
    assign w_th_wr   = memwrite && w_sel && (addr[3:2] == 2'd0);
    assign w_tl_wr   = memwrite && w_sel && (addr[3:2] == 2'd1);
    assign w_tcon_wr = memwrite && w_sel && (addr[3:2] == 2'd2);

    assign w_ten_new = w_tcon_wr ? wdata[0] : r_ten;
    assign w_ien_new = w_tcon_wr ? wdata[1] : r_ien;

`ifdef TIMER_ONESHOT_EN
    assign w_osm_new = w_tcon_wr ? wdata[3] : r_osm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_osm <= 1'b0;
        end else begin
            r_osm <= w_osm_new;
        end
    end
`else
    assign w_osm_new = 1'b0;

    always_ff @(posedge clk) begin
        r_osm <= 1'b0;
    end
`endif

    // Writing TEN=0 stops counting on the same edge; enabling starts on the next one.
    assign w_tick = r_ten && w_ten_new && (r_pcnt == PMAX);
    // A TL store beats the tick, so it also suppresses the overflow.
    assign w_ovf  = w_tick && !w_tl_wr && (r_tl == 32'hFFFF_FFFF);

    assign w_tcon_rd = {28'd0, r_osm, r_ist, r_ien, r_ten};

    always_comb begin
        rdata = 32'h0;
        if (memread && w_sel) begin
            case (addr[3:2])
                2'd0:    rdata = r_th;
                2'd1:    rdata = r_tl;
                2'd2:    rdata = w_tcon_rd;
                default: rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_th   <= 32'h0;
            r_tl   <= 32'h0;
            r_pcnt <= 16'h0;
            r_ten  <= 1'b0;
            r_ien  <= 1'b0;
            r_ist  <= 1'b0;
            irqout <= 1'b0;
        end else begin
            if (w_tcon_wr || !r_ten || w_tick) begin
                r_pcnt <= 16'h0;
            end else begin
                r_pcnt <= r_pcnt + 16'd1;
            end

            if (w_th_wr) begin
                r_th <= wdata;
            end

            // Reload uses the pre-store TH even when TH is written this edge.
            if (w_tl_wr) begin
                r_tl <= wdata;
            end else if (w_tick) begin
                r_tl <= w_ovf ? r_th : r_tl + 32'd1;
            end

            r_ten  <= w_ten_new && !(w_ovf && w_osm_new);
            r_ien  <= w_ien_new;
            // An overflow on the same edge as a clearing store keeps the request.
            r_ist  <= (w_tcon_wr ? wdata[2] : r_ist) | (w_ovf & w_ien_new);
            irqout <= r_ien & r_ist;
        end
    end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
- Memory-mapped timer and interrupt-request controller on the single-cycle MIPS CPU's peripheral bus, at base 0x4000_0000.
- Holds TH (reload), TL (counter) and TCON (control/status).
- Raises the interrupt line that vectors the CPU to its exception handler.
- The handler clears the request through TCON and re-arms it, which sequences the 7-seg scan interrupts.

Parameters:
- BASE_ADDR, 32'h4000_0000, byte address of TH; TL at +4, TCON at +8.
- PRESCALE, 1, clk cycles per TL increment (1..65535).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- addr  input  32  CPU data-memory byte address.
- wdata  input  32  CPU store data.
- memread  input  1  load strobe.
- memwrite  input  1  store strobe, sampled at clk edge.
- rdata  output  32  combinational read data.
- irqout  output  1  registered interrupt request to the CPU.

Behaviour:
- Decode: selected when addr[31:4] matches BASE_ADDR[31:4] and addr[3:2] is 0, 1 or 2. addr[1:0] is ignored. Offset 0xC and above is not claimed.
- Read path: rdata = selected register when memread & selected, else 32'h0. Pure combinational, zero latency; the single-cycle CPU needs this.
- TCON bits:
  - [0] TEN: count enable.
  - [1] IEN: interrupt enable.
  - [2] IST: interrupt status.
  - [31:3] read 0; writes to them are ignored.
- Reset values: TH=0, TL=0, TCON=0, prescale counter=0, irqout=0.
- Prescaler:
  - Counter runs 0..PRESCALE-1 while TEN=1 and produces a tick on wrap.
  - Held at 0 while TEN=0.
  - Cleared on any TCON write.
  - PRESCALE=1 gives a tick every enabled cycle.
- Count: on tick, if TL==32'hFFFF_FFFF then TL<=TH (old TH value) and an overflow event occurs; else TL<=TL+1.
- Overflow event: if IEN=1, set IST. If IEN=0, IST is unchanged.
- irqout <= IEN & IST, registered, so it asserts 1 cycle after IST is set.
- Stores: on clk edge with memwrite & selected, write TH, TL or TCON[2:0].
- Simultaneous events:
  - TL store vs tick: store wins, no increment and no overflow that cycle.
  - TH store vs overflow: TL reloads the pre-store TH; TH takes the new value.
  - TCON store clearing IST vs overflow setting IST: IST ends 1 (no lost interrupt). The IEN used is the newly written value.
  - TCON store with TEN=0: counting stops the same edge; TL holds.
- Reset mid-count or mid-interrupt returns all state to reset values the next edge; irqout drops that edge.
- TL wrap-around: 32'hFFFF_FFFF reloads from TH, never rolls to 0 unless TH=0.

Optional Feature:
- Macro TIMER_ONESHOT_EN.
- When defined:
  - TCON[3] is OSM (one-shot mode), R/W, reset 0.
  - On overflow with OSM=1, TEN is cleared on the same edge as the TL reload; the timer stops after one period.
  - OSM=0 behaves as periodic.
- When undefined: TCON[3] reads 0, writes ignored, timer always periodic.

Test Plan:
- Reset then read TH/TL/TCON -> all 32'h0, irqout=0; read of 0x4000_000C -> rdata=0.
- PRESCALE=1: TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, TCON=3 -> TL goes FFFF_FFFF, then FFFF_FFFC; IST=1 on the reload edge; irqout=1 one cycle later; TCON reads 0x7.
- With irq pending, store TCON=0x1 -> IST=IEN=0, irqout=0 next edge. Then store TCON=0x3 -> counting continues, next overflow after 4 ticks from TH reload.
- Store TCON=0x3 on the same edge as an overflow -> TCON reads 0x7 and irqout asserts.
- PRESCALE=4, TEN=1, TL=0 -> TL=1 after 4 cycles and TL=2 after 8; store TEN=0 mid-count -> TL frozen.
- TIMER_ONESHOT_EN: TCON=0xB, TL=0xFFFF_FFFF -> one overflow, TCON reads 0xE, TL stays at the TH value thereafter.
